// File: rtl/k28_pkg.sv
// Shared definitions for the 8b/10b receive word-alignment logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the alignment FSM state encoding and both running-disparity
// encodings of the K28.5 comma.
package k28_pkg;

    // Encoding is visible on the lock_state port: 0 HUNT, 1 VERIFY, 2 LOCKED.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    // K28.5 as transmitted, bit a in [9] through bit j in [0].
    localparam logic [9:0] K285_RDN = 10'b0011111010;
    localparam logic [9:0] K285_RDP = 10'b1100000101;

    // Last bit position of a 10-bit symbol.
    localparam logic [3:0] BIT_CNT_LAST = 4'd9;

endpackage

// File: rtl/k28_comma_match.sv
// K28.5 comma detector for a 10-bit window, either running disparity.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   sym_in  in  10  candidate symbol, [9] oldest bit
//   comma   out 1   sym_in equals K28.5 (RD- or RD+)
module k28_comma_match
    import k28_pkg::*;
(
    input  logic [9:0] sym_in,
    output logic       comma
);

    assign comma = (sym_in == K285_RDN) || (sym_in == K285_RDP);

endmodule

// File: rtl/comma_align_ctrl.sv
// Receive word aligner: deserializes, hunts K28.5, locks symbol boundary.
// Latency: 2 CRCLK from last bit of a symbol on serial_in to SYMBOL_CLK.
// Backpressure: none; output is a free-running strobed stream.
//
// Ports:
//   CRCLK       in  1   recovered bit clock, all logic on posedge
//   Reset       in  1   asynchronous active-low reset
//   serial_in   in  1   received bit, first-transmitted bit first
//   symbol_out  out 10  aligned symbol, [9] oldest bit (a), [0] newest (j)
//   SYMBOL_CLK  out 1   one-cycle strobe: symbol_out updated this cycle
//   RXVALID     out 1   symbol_out valid while locked; only with SYMBOL_CLK
//   comma_out   out 1   symbol_out is K28.5; qualified by SYMBOL_CLK
//   lock_state  out 2   0 HUNT, 1 VERIFY, 2 LOCKED
module comma_align_ctrl
    import k28_pkg::*;
#(
    parameter int LOCK_COUNT     = 3,
    parameter int LOSS_COUNT     = 4,
    parameter int VERIFY_TIMEOUT = 16
) (
    input  logic       CRCLK,
    input  logic       Reset,
    input  logic       serial_in,
    output logic [9:0] symbol_out,
    output logic       SYMBOL_CLK,
    output logic       RXVALID,
    output logic       comma_out,
    output logic [1:0] lock_state
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(LOSS_COUNT + 1);
    localparam int SW = $clog2(VERIFY_TIMEOUT + 1);

    localparam logic [GW-1:0] LOCK_MAX = GW'(LOCK_COUNT);
    localparam logic [EW-1:0] LOSS_MAX = EW'(LOSS_COUNT);
    localparam logic [SW-1:0] VT_MAX   = SW'(VERIFY_TIMEOUT);
    localparam logic [GW-1:0] G_ONE    = GW'(1);
    localparam logic [EW-1:0] E_ONE    = EW'(1);
    localparam logic [SW-1:0] S_ONE    = SW'(1);

    // Sliding window and bit phase within the current symbol.
    logic [9:0]  sr_q, sr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;

    // Alignment FSM and its counters.
    lock_state_e state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [EW-1:0] err_q, err_d;
    logic [SW-1:0] sym_q, sym_d;

    // Registered outputs.
    logic [9:0]  symbol_q, symbol_d;
    logic        sym_clk_q, sym_clk_d;
    logic        rxvalid_q, rxvalid_d;
    logic        comma_out_q, comma_out_d;

    logic        comma;
    logic        at_bnd;
    logic        realign;
    logic        boundary;
    logic [GW-1:0] good_sat;
    logic [EW-1:0] err_sat;
    logic [SW-1:0] sym_sat;

    k28_comma_match u_comma_match (
        .sym_in (sr_q),
        .comma  (comma)
    );

    // Saturating increments: counters hold once they hit their threshold.
    assign good_sat = (good_q == LOCK_MAX) ? good_q : good_q + G_ONE;
    assign err_sat  = (err_q  == LOSS_MAX) ? err_q  : err_q  + E_ONE;
    assign sym_sat  = (sym_q  == VT_MAX)   ? sym_q  : sym_q  + S_ONE;

    assign at_bnd = (bit_cnt_q == BIT_CNT_LAST);

    always_comb begin
        sr_d    = {sr_q[8:0], serial_in};
        state_d = state_q;
        good_d  = good_q;
        err_d   = err_q;
        sym_d   = sym_q;
        realign = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (comma) begin
                    realign = 1'b1;
                    good_d  = G_ONE;
                    sym_d   = '0;
                    if (LOCK_COUNT == 1) begin
                        state_d = LOCKED;
                        err_d   = '0;
                    end else begin
                        state_d = VERIFY;
                    end
                end
            end
            VERIFY: begin
                if (comma && at_bnd) begin
                    good_d = good_sat;
                    if (good_sat == LOCK_MAX) begin
                        state_d = LOCKED;
                        err_d   = '0;
                    end
                end else if (comma) begin
                    // Comma at a new phase: restart verification there.
                    realign = 1'b1;
                    good_d  = G_ONE;
                    sym_d   = '0;
                end else if (at_bnd) begin
                    sym_d = sym_sat;
                    if (sym_sat == VT_MAX) begin
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                // Once locked, stray commas are counted, never followed.
                if (comma && at_bnd) begin
                    err_d = '0;
                end else if (comma) begin
                    if (err_sat == LOSS_MAX) begin
                        state_d = HUNT;
                        err_d   = '0;
                    end else begin
                        err_d = err_sat;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        // A realign makes the current window a symbol; either way the
        // next symbol starts at bit position 0.
        boundary    = at_bnd || realign;
        bit_cnt_d   = boundary ? 4'd0 : bit_cnt_q + 4'd1;

        symbol_d    = boundary ? sr_q  : symbol_q;
        comma_out_d = boundary ? comma : comma_out_q;
        sym_clk_d   = boundary;
        rxvalid_d   = boundary && (state_d == LOCKED);
    end

    always_ff @(posedge CRCLK or negedge Reset) begin
        if (!Reset) begin
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            state_q     <= HUNT;
            good_q      <= '0;
            err_q       <= '0;
            sym_q       <= '0;
            symbol_q    <= '0;
            sym_clk_q   <= 1'b0;
            rxvalid_q   <= 1'b0;
            comma_out_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            state_q     <= state_d;
            good_q      <= good_d;
            err_q       <= err_d;
            sym_q       <= sym_d;
            symbol_q    <= symbol_d;
            sym_clk_q   <= sym_clk_d;
            rxvalid_q   <= rxvalid_d;
            comma_out_q <= comma_out_d;
        end
    end

    assign symbol_out = symbol_q;
    assign SYMBOL_CLK = sym_clk_q;
    assign RXVALID    = rxvalid_q;
    assign comma_out  = comma_out_q;
    assign lock_state = state_q;

endmodule

// File: doc/comma_align_ctrl.md
# comma_align_ctrl

Receive-side word-alignment controller for the serial 8b/10b link. Deserializes the bit stream on CRCLK, hunts for the K28.5 comma in a sliding 10-bit window, and realigns the symbol boundary on it. Declares lock after a programmable number of consecutive aligned commas, then drops lock after repeated misaligned commas. Feeds the aligned 10-bit symbol, SYMBOL_CLK strobe and RXVALID to the downstream decoder.

## Interface
- LOCK_COUNT, 3: aligned commas needed in VERIFY to enter LOCKED (≥1)
- LOSS_COUNT, 4: misaligned commas in LOCKED that force HUNT (≥1)
- VERIFY_TIMEOUT, 16: boundaries without comma in VERIFY before return to HUNT
- CRCLK  in  1  bit-rate recovered clock; the block's single clock, all logic on posedge
- Reset  in  1  asynchronous, active-low reset
- serial_in  in  1  received bit, first-transmitted bit first
- symbol_out  out  10  aligned symbol; [9] is the oldest bit (a), [0] the newest (j)
- SYMBOL_CLK  out  1  one-CRCLK strobe: symbol_out updated this cycle
- RXVALID  out  1  symbol_out valid and locked; only ever high together with SYMBOL_CLK
- comma_out  out  1  symbol_out is K28.5; qualified by SYMBOL_CLK
- lock_state  out  2  0 HUNT, 1 VERIFY, 2 LOCKED

## Operation
- sr[9:0] <= {sr[8:0], serial_in} every cycle; comma = (sr == 10'b0011111010) | (sr == 10'b1100000101).
- bit_cnt 0..9 increments every cycle and wraps 9→0; boundary = (bit_cnt == 9) or realign.
- Realign: bit_cnt <= 0; the current sr is treated as a boundary symbol.
- At every boundary: symbol_out <= sr, SYMBOL_CLK <= 1, comma_out <= comma, RXVALID <= (next state == LOCKED).
- HUNT: bit_cnt free-runs. Any comma → realign, good_cnt <= 1, sym_cnt <= 0, go to VERIFY.
- VERIFY:
  - Comma at boundary: good_cnt+1. If this reaches LOCK_COUNT, go to LOCKED, err_cnt <= 0.
  - Non-comma boundary: sym_cnt+1. Reaching VERIFY_TIMEOUT → HUNT.
  - Comma off boundary: realign, good_cnt <= 1, sym_cnt <= 0, stay in VERIFY.
- LOCKED:
  - Comma at boundary: err_cnt <= 0.
  - Comma off boundary: no realign, err_cnt+1. Reaching LOSS_COUNT → HUNT (no realign that cycle), err_cnt <= 0.
  - Non-comma boundary: no change.
- LOCK_COUNT = 1: the first HUNT comma goes directly to LOCKED.
- Counters saturate at their thresholds. Widths are $clog2(param+1).

## Timing
- Reset (async, low): sr = 0, bit_cnt = 0, state HUNT, all counters 0. All outputs 0; lock_state = 0.
- Latency from the last bit of a symbol on serial_in to SYMBOL_CLK/symbol_out: 2 CRCLK cycles (sr register, then output register).
- Aligned strobes: SYMBOL_CLK pulses exactly every 10 cycles, one cycle wide.
- After a realign, the next strobe comes exactly 10 cycles after the realign strobe.
- RXVALID is high on the strobe of the symbol that completes lock.
- RXVALID is low from the strobe after the loss transition.
- lock_state is registered and changes in the same cycle as the strobe or error that caused it.
- Reset asserted mid-symbol: everything clears immediately. The first post-reset strobe comes at bit_cnt wrap or a comma, whichever occurs first.

## Structure
- Package k28_pkg holds:
  - state enum (HUNT/VERIFY/LOCKED)
  - K285_RDN = 10'b0011111010
  - K285_RDP = 10'b1100000101
- Sub-module k28_comma_match: combinational, sr in → comma out, compares against both disparities. Shared with the transmit-side checker.
- Rest stays in one module: shift register, bit_cnt, FSM with good/err/sym counters, output registers.

## Test plan
- Reset release, all-zero input for 50 cycles → SYMBOL_CLK every 10 cycles, RXVALID = 0, lock_state = 0, comma_out = 0.
- 7 random bits, then RD- K28.5 alternating with D-symbols every 10 bits. Expected:
  - First comma → realign, lock_state = 1.
  - Third aligned comma (LOCK_COUNT = 3) → lock_state = 2; RXVALID = 1 on that strobe with symbol_out = 10'h0FA.
- Locked stream, then slip the stream by 2 bits, commas continuing. Expected:
  - Four misaligned commas → lock_state = 0 after the fourth.
  - Next comma realigns → VERIFY.
- VERIFY entered, then 16 comma-free symbols → back to HUNT on the 16th strobe, RXVALID never asserted.
- Locked, RD+ comma (10'h305) on boundary after 3 misaligned commas → err_cnt cleared; 3 further misaligned commas do not drop lock.
- Reset pulse low for 1 cycle while LOCKED mid-symbol → all outputs 0 immediately, lock_state = 0; relock after 3 aligned commas.
